// File: rtl/e203_nice_csr_bridge_pkg.sv
// rtl/e203_nice_csr_bridge_pkg.sv - shared types and constants for the NICE CSR bridge
package e203_nice_csr_bridge_pkg;

  localparam int NICE_CSR_ADDR_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } bridge_state_e;

endpackage

// File: rtl/e203_nice_csr_bridge_if.sv
// rtl/e203_nice_csr_bridge_if.sv - core-side and NICE-side CSR handshake signals of the bridge
interface e203_nice_csr_bridge_if
  import e203_nice_csr_bridge_pkg::*;
#(
  parameter int CSR_ADDR_W = 12
);

  logic                       csr_req_valid;
  logic                       csr_req_ready;
  logic [CSR_ADDR_W-1:0]      csr_req_addr;
  logic                       csr_req_wr;
  logic [31:0]                csr_req_wdata;
  logic                       csr_rsp_valid;
  logic                       csr_rsp_ready;
  logic [31:0]                csr_rsp_rdata;
  logic                       csr_rsp_err;
  logic                       csr_flush;
  logic                       nice_csr_valid;
  logic                       nice_csr_ready;
  logic [NICE_CSR_ADDR_W-1:0] nice_csr_addr;
  logic                       nice_csr_wr;
  logic [31:0]                nice_csr_wdata;
  logic [31:0]                nice_csr_rdata;

  // slave: the bridge itself; master: the surrounding core and CSR target
  modport slave (
    input  csr_req_valid, csr_req_addr, csr_req_wr, csr_req_wdata,
    input  csr_rsp_ready, csr_flush, nice_csr_ready, nice_csr_rdata,
    output csr_req_ready, csr_rsp_valid, csr_rsp_rdata, csr_rsp_err,
    output nice_csr_valid, nice_csr_addr, nice_csr_wr, nice_csr_wdata
  );

  modport master (
    output csr_req_valid, csr_req_addr, csr_req_wr, csr_req_wdata,
    output csr_rsp_ready, csr_flush, nice_csr_ready, nice_csr_rdata,
    input  csr_req_ready, csr_rsp_valid, csr_rsp_rdata, csr_rsp_err,
    input  nice_csr_valid, nice_csr_addr, nice_csr_wr, nice_csr_wdata
  );

endinterface

// File: rtl/e203_nice_csr_bridge.sv
// rtl/e203_nice_csr_bridge.sv - single-outstanding core CSR to NICE CSR bridge with timeout
module e203_nice_csr_bridge
  import e203_nice_csr_bridge_pkg::*;
#(
  parameter int CSR_ADDR_W  = 12,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  e203_nice_csr_bridge_if.slave  bus
);

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

  bridge_state_e         state_q, state_d;
  logic [CSR_ADDR_W-1:0] addr_q;
  logic                  wr_q;
  logic [31:0]           wdata_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  req_accept;
  logic                  rsp_load;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d            = state_q;
    req_accept         = 1'b0;
    rsp_load           = 1'b0;
    rsp_rdata_d        = '0;
    rsp_err_d          = 1'b0;
    bus.csr_req_ready  = 1'b0;
    bus.nice_csr_valid = 1'b0;
    bus.csr_rsp_valid  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.csr_req_ready = 1'b1;
        if (bus.csr_req_valid && !bus.csr_flush) begin
          req_accept = 1'b1;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        bus.nice_csr_valid = 1'b1;
        // Flush beats a coincident handshake: the target saw the access, the core does not
        if (bus.csr_flush) begin
          state_d = ST_IDLE;
        end else if (bus.nice_csr_ready) begin
          rsp_load    = 1'b1;
          rsp_rdata_d = wr_q ? 32'h0 : bus.nice_csr_rdata;
          state_d     = ST_RSP;
        end else if ((TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST)) begin
          rsp_load  = 1'b1;
          rsp_err_d = 1'b1;
          state_d   = ST_RSP;
        end
      end
      ST_RSP: begin
        bus.csr_rsp_valid = 1'b1;
        if (bus.csr_flush || bus.csr_rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (req_accept) begin
        addr_q  <= bus.csr_req_addr;
        wr_q    <= bus.csr_req_wr;
        wdata_q <= bus.csr_req_wdata;
        cnt_q   <= '0;
      end else if ((state_q == ST_REQ) && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (rsp_load) begin
        rsp_rdata_q <= rsp_rdata_d;
        rsp_err_q   <= rsp_err_d;
      end
    end
  end

  assign bus.nice_csr_addr  = NICE_CSR_ADDR_W'(addr_q);
  assign bus.nice_csr_wr    = wr_q;
  assign bus.nice_csr_wdata = wdata_q;
  assign bus.csr_rsp_rdata  = rsp_rdata_q;
  assign bus.csr_rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_e203_nice_csr_bridge.sv
// tb/tb_e203_nice_csr_bridge.sv - table-driven bench for the NICE CSR bridge
module tb_e203_nice_csr_bridge;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  e203_nice_csr_bridge_if #(.CSR_ADDR_W(12)) bus ();

  e203_nice_csr_bridge #(.CSR_ADDR_W(12), .TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] tgt;
    int          delay;
    int          rsp_wait;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_cycles;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic [11:0] addr, input logic wr, input logic [31:0] wdata);
    bus.csr_req_valid = 1'b1;
    bus.csr_req_addr  = addr;
    bus.csr_req_wr    = wr;
    bus.csr_req_wdata = wdata;
    tick();
    bus.csr_req_valid = 1'b0;
  endtask

  task automatic run_vec(input int i);
    int nvalid = 0;
    int unstable = 0;
    int bp_bad = 0;
    chk1($sformatf("v%0d_req_ready_idle", i), bus.csr_req_ready, 1'b1);
    start_req(vecs[i].addr, vecs[i].wr, vecs[i].wdata);
    for (int c = 0; c < 20; c++) begin
      if (!bus.nice_csr_valid) break;
      nvalid++;
      if (bus.nice_csr_addr !== {20'h0, vecs[i].addr} || bus.nice_csr_wr !== vecs[i].wr ||
          bus.nice_csr_wdata !== vecs[i].wdata || bus.csr_rsp_valid !== 1'b0) unstable++;
      bus.nice_csr_ready = (c == vecs[i].delay);
      bus.nice_csr_rdata = (c == vecs[i].delay) ? vecs[i].tgt : (32'hBAD0_0000 + 32'(c));
      tick();
    end
    bus.nice_csr_ready = 1'b0;
    chk($sformatf("v%0d_valid_cycles", i), 32'(nvalid), 32'(vecs[i].exp_cycles));
    chk($sformatf("v%0d_req_stable", i), 32'(unstable), 32'h0);
    chk1($sformatf("v%0d_rsp_valid", i), bus.csr_rsp_valid, 1'b1);
    for (int w = 0; w < vecs[i].rsp_wait; w++) begin
      bus.csr_req_valid = 1'b1;
      bus.csr_req_addr  = 12'h555;
      if (bus.csr_rsp_valid !== 1'b1 || bus.csr_rsp_rdata !== vecs[i].exp_rdata ||
          bus.csr_rsp_err !== vecs[i].exp_err || bus.csr_req_ready !== 1'b0) bp_bad++;
      tick();
    end
    bus.csr_req_valid = 1'b0;
    if (vecs[i].rsp_wait > 0) chk($sformatf("v%0d_backpressure", i), 32'(bp_bad), 32'h0);
    chk($sformatf("v%0d_rsp_rdata", i), bus.csr_rsp_rdata, vecs[i].exp_rdata);
    chk1($sformatf("v%0d_rsp_err", i), bus.csr_rsp_err, vecs[i].exp_err);
    chk1($sformatf("v%0d_req_ready_rsp", i), bus.csr_req_ready, 1'b0);
    bus.csr_rsp_ready = 1'b1;
    tick();
    bus.csr_rsp_ready = 1'b0;
    chk1($sformatf("v%0d_rsp_done", i), bus.csr_rsp_valid, 1'b0);
    chk1($sformatf("v%0d_back_idle", i), bus.csr_req_ready, 1'b1);
    chk1($sformatf("v%0d_no_new_req", i), bus.nice_csr_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 12'h7C0, 32'h0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 1'b0, 1};
    vecs[1] = '{1'b1, 12'h7C1, 32'h12345678, 32'hFFFFFFFF, 3, 0, 32'h0, 1'b0, 4};
    vecs[2] = '{1'b0, 12'h7FF, 32'h0, 32'hA5A55A5A, 2, 5, 32'hA5A55A5A, 1'b0, 3};
    vecs[3] = '{1'b0, 12'h123, 32'h0, 32'h11111111, 99, 0, 32'h0, 1'b1, 4};
    vecs[4] = '{1'b1, 12'h800, 32'hCAFEF00D, 32'h22222222, 99, 2, 32'h0, 1'b1, 4};
    vecs[5] = '{1'b0, 12'hFFF, 32'h0, 32'h0BADF00D, 3, 0, 32'h0BADF00D, 1'b0, 4};
    vecs[6] = '{1'b0, 12'h000, 32'h0, 32'h00000001, 1, 1, 32'h00000001, 1'b0, 2};

    bus.csr_req_valid  = 1'b0;
    bus.csr_req_addr   = '0;
    bus.csr_req_wr     = 1'b0;
    bus.csr_req_wdata  = '0;
    bus.csr_rsp_ready  = 1'b0;
    bus.csr_flush      = 1'b0;
    bus.nice_csr_ready = 1'b0;
    bus.nice_csr_rdata = '0;

    repeat (2) tick();
    chk1("reset_req_ready", bus.csr_req_ready, 1'b1);
    chk1("reset_nice_valid", bus.nice_csr_valid, 1'b0);
    chk1("reset_rsp_valid", bus.csr_rsp_valid, 1'b0);
    chk("reset_rsp_rdata", bus.csr_rsp_rdata, 32'h0);
    chk("reset_nice_addr", bus.nice_csr_addr, 32'h0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_vec(i);

    // flush while the target stalls
    start_req(12'h300, 1'b0, 32'h0);
    tick();
    chk1("flush_req_pre", bus.nice_csr_valid, 1'b1);
    bus.csr_flush = 1'b1;
    tick();
    bus.csr_flush = 1'b0;
    chk1("flush_req_valid_drop", bus.nice_csr_valid, 1'b0);
    chk1("flush_req_ready", bus.csr_req_ready, 1'b1);
    tick();
    chk1("flush_req_no_rsp", bus.csr_rsp_valid, 1'b0);

    // flush coinciding with the target handshake
    start_req(12'h301, 1'b0, 32'h0);
    bus.csr_flush      = 1'b1;
    bus.nice_csr_ready = 1'b1;
    bus.nice_csr_rdata = 32'h77777777;
    tick();
    bus.csr_flush      = 1'b0;
    bus.nice_csr_ready = 1'b0;
    chk1("flush_hs_no_rsp", bus.csr_rsp_valid, 1'b0);
    chk1("flush_hs_idle", bus.csr_req_ready, 1'b1);

    // flush in idle blocks acceptance
    bus.csr_flush = 1'b1;
    start_req(12'h302, 1'b0, 32'h0);
    bus.csr_flush = 1'b0;
    chk1("flush_idle_not_taken", bus.nice_csr_valid, 1'b0);

    // flush while the response waits
    start_req(12'h303, 1'b0, 32'h0);
    bus.nice_csr_ready = 1'b1;
    bus.nice_csr_rdata = 32'h5A5A0000;
    tick();
    bus.nice_csr_ready = 1'b0;
    chk1("flush_rsp_pre", bus.csr_rsp_valid, 1'b1);
    bus.csr_flush = 1'b1;
    tick();
    bus.csr_flush = 1'b0;
    chk1("flush_rsp_drop", bus.csr_rsp_valid, 1'b0);
    chk1("flush_rsp_idle", bus.csr_req_ready, 1'b1);

    // reset in the middle of a request, then a normal read
    start_req(12'h7C0, 1'b1, 32'hFEEDFACE);
    chk1("rst_mid_pre", bus.nice_csr_valid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk1("rst_mid_nice_valid", bus.nice_csr_valid, 1'b0);
    chk1("rst_mid_req_ready", bus.csr_req_ready, 1'b1);
    chk("rst_mid_nice_wdata", bus.nice_csr_wdata, 32'h0);
    chk1("rst_mid_rsp_valid", bus.csr_rsp_valid, 1'b0);
    run_vec(0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
